// File: rtl/tbird_pkg.sv
// Shared types and lamp patterns for the tail-light sequencer.
package tbird_pkg;

  typedef enum logic [2:0] {IDLE, L1, L2, L3, R1, R2, R3, HZ} state_t;

  // Lamp order is {lc,lb,la,ra,rb,rc}.
  localparam logic [5:0] LIGHTS_IDLE = 6'b000_000;
  localparam logic [5:0] LIGHTS_L1   = 6'b001_000;
  localparam logic [5:0] LIGHTS_L2   = 6'b011_000;
  localparam logic [5:0] LIGHTS_L3   = 6'b111_000;
  localparam logic [5:0] LIGHTS_R1   = 6'b000_100;
  localparam logic [5:0] LIGHTS_R2   = 6'b000_110;
  localparam logic [5:0] LIGHTS_R3   = 6'b000_111;
  localparam logic [5:0] LIGHTS_HZ   = 6'b111_111;

  function automatic logic [5:0] lights_of(input state_t s);
    case (s)
      L1:      return LIGHTS_L1;
      L2:      return LIGHTS_L2;
      L3:      return LIGHTS_L3;
      R1:      return LIGHTS_R1;
      R2:      return LIGHTS_R2;
      R3:      return LIGHTS_R3;
      HZ:      return LIGHTS_HZ;
      default: return LIGHTS_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchroniser for asynchronous switch inputs.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk) begin
    if (!rst) sr <= '0;
    else      sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/tbird_seq.sv
// Tail-light sequencer: synchronised switches drive a Moore FSM stepped on tick.
module tbird_seq
  import tbird_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             left_sw,
  input  logic             right_sw,
  input  logic             hazard_sw,
  output logic [5:0]       lights,
  output logic [CNT_W-1:0] seq_count,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic   l_s, r_s, h_s;
  state_t state, nxt;
  logic   seq_done;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_l (.clk(clk), .rst(rst), .d(left_sw),   .q(l_s));
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_r (.clk(clk), .rst(rst), .d(right_sw),  .q(r_s));
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_h (.clk(clk), .rst(rst), .d(hazard_sw), .q(h_s));

  // Hazard (or both turn switches) outranks everything and toggles HZ/IDLE.
  always_comb begin
    nxt = state;
    if (h_s || (l_s && r_s)) begin
      nxt = (state == HZ) ? IDLE : HZ;
    end else begin
      case (state)
        IDLE:    nxt = l_s ? L1 : (r_s ? R1 : IDLE);
        L1:      nxt = L2;
        L2:      nxt = L3;
        L3:      nxt = IDLE;
        R1:      nxt = R2;
        R2:      nxt = R3;
        R3:      nxt = IDLE;
        HZ:      nxt = IDLE;
        default: nxt = IDLE;
      endcase
    end
  end

  assign seq_done = ((state == L3) || (state == R3)) && (nxt == IDLE);

  // tick is a single-cycle enable: every edge that sees it high advances one step,
  // and all registered state holds while it is low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      lights    <= LIGHTS_IDLE;
      busy      <= 1'b0;
      seq_count <= '0;
    end else if (tick) begin
      state  <= nxt;
      lights <= lights_of(nxt);
      busy   <= (nxt != IDLE);
      if (seq_done && (seq_count != CNT_MAX)) seq_count <= seq_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_tbird_seq.sv
// Directed bench for tbird_seq with a 2-bit counter so saturation is reachable.
module tb_tbird_seq;

  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             clk, rst, tick, left_sw, right_sw, hazard_sw;
  logic [5:0]       lights;
  logic [CNT_W-1:0] seq_count;
  logic             busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [CNT_W-1:0] exp_cnt;

  tbird_seq #(.SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .left_sw(left_sw), .right_sw(right_sw), .hazard_sw(hazard_sw),
    .lights(lights), .seq_count(seq_count), .busy(busy)
  );

  // clock/reset
  initial begin
    clk = 1'b0;
    forever #4 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change on negedge, outputs are read on negedge
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic step(input string tag, input logic [5:0] exp_l);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check(tag, {26'd0, lights}, {26'd0, exp_l});
    check({tag, "_busy"}, {31'd0, busy}, {31'd0, exp_l != 6'b000_000});
  endtask

  task automatic settle();
    cycles(SYNC_STAGES + 1);
  endtask

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  initial begin
    rst = 1'b0; tick = 1'b1;
    left_sw = 1'b1; right_sw = 1'b1; hazard_sw = 1'b1;
    exp_cnt = '0;

    // reset dominates tick and switches
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_lights", {26'd0, lights}, 32'd0);
      check("rst_cnt", {30'd0, seq_count}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
    end
    rst = 1'b1; tick = 1'b0;
    left_sw = 1'b0; right_sw = 1'b0; hazard_sw = 1'b0;
    settle();
    check("idle_after_rst", {26'd0, lights}, 32'd0);

    // left sequence
    left_sw = 1'b1;
    settle();
    step("left1", 6'b001_000);
    step("left2", 6'b011_000);
    step("left3", 6'b111_000);
    step("left_end", 6'b000_000);
    exp_cnt = sat_inc(exp_cnt);
    check("left_cnt", {30'd0, seq_count}, {30'd0, exp_cnt});
    left_sw = 1'b0;
    settle();

    // right sequence, switch dropped after the first step
    right_sw = 1'b1;
    settle();
    step("right1", 6'b000_100);
    right_sw = 1'b0;
    settle();
    step("right2", 6'b000_110);
    step("right3", 6'b000_111);
    step("right_end", 6'b000_000);
    exp_cnt = sat_inc(exp_cnt);
    check("right_cnt", {30'd0, seq_count}, {30'd0, exp_cnt});

    // hazard interrupts a left sequence at L2, then blinks
    left_sw = 1'b1;
    settle();
    step("hz_l1", 6'b001_000);
    step("hz_l2", 6'b011_000);
    hazard_sw = 1'b1;
    settle();
    step("hz_on", 6'b111_111);
    step("hz_off", 6'b000_000);
    step("hz_on2", 6'b111_111);
    check("hz_cnt", {30'd0, seq_count}, {30'd0, exp_cnt});
    hazard_sw = 1'b0; left_sw = 1'b0;
    settle();
    step("hz_release", 6'b000_000);
    check("hz_cnt2", {30'd0, seq_count}, {30'd0, exp_cnt});

    // both turn switches act as hazard; no tick means hold
    left_sw = 1'b1; right_sw = 1'b1;
    settle();
    step("both_on", 6'b111_111);
    for (int i = 0; i < 2; i++) begin
      cycles(250);
      check("hold_on", {26'd0, lights}, 32'h3f);
    end
    step("both_off", 6'b000_000);
    for (int i = 0; i < 4; i++) begin
      cycles(250);
      check("hold_off", {26'd0, lights}, 32'd0);
      check("hold_cnt", {30'd0, seq_count}, {30'd0, exp_cnt});
    end
    left_sw = 1'b0; right_sw = 1'b0;
    settle();

    // saturation over five more left sequences
    for (int n = 0; n < 5; n++) begin
      left_sw = 1'b1;
      settle();
      step("sat_l1", 6'b001_000);
      step("sat_l2", 6'b011_000);
      step("sat_l3", 6'b111_000);
      step("sat_end", 6'b000_000);
      exp_cnt = sat_inc(exp_cnt);
      check("sat_cnt", {30'd0, seq_count}, {30'd0, exp_cnt});
      left_sw = 1'b0;
      settle();
    end
    check("sat_final", {30'd0, seq_count}, {30'd0, CNT_MAX});

    // reset in the middle of a sequence, then restart from IDLE
    left_sw = 1'b1;
    settle();
    step("mid_l1", 6'b001_000);
    step("mid_l2", 6'b011_000);
    rst = 1'b0; tick = 1'b1;
    @(negedge clk);
    check("mid_rst_lights", {26'd0, lights}, 32'd0);
    check("mid_rst_cnt", {30'd0, seq_count}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1; tick = 1'b0;
    settle();
    step("restart_l1", 6'b001_000);
    check("restart_cnt", {30'd0, seq_count}, 32'd0);
    left_sw = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
